uart_crc_link: RTL
==================

UART_CRC_LINK -- requirements
Module: uart_crc_link

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit, legal 4..65535.
REQ-002 Parameter DATA_BYTES, default 4: payload bytes per frame, legal 1..64.
REQ-003 Parameter IDLE_TIMEOUT_BITS, default 32: idle bit-times after which a partial RX frame is discarded.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tx_data  input  8  payload byte offered for transmission.
REQ-007 tx_valid  input  1  tx_data valid.
REQ-008 tx_ready  output  1  block accepts tx_data this cycle.
REQ-009 tx_out  output  1  serial line out, idle high.
REQ-010 tx_busy  output  1  a frame is in progress.
REQ-011 rx_in  input  1  serial line in, asynchronous to clk.
REQ-012 rx_data  output  8  received payload byte.
REQ-013 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-014 rx_frame_done  output  1  one-cycle pulse at end of a complete frame.
REQ-015 rx_crc_ok  output  1  CRC match result, valid while rx_frame_done high.
REQ-016 rx_frame_err  output  1  one-cycle pulse on stop-bit error or timeout discard.

Function
REQ-017 Frame = DATA_BYTES payload bytes, then CRC high byte, then CRC low byte; each byte = start(0), 8 data bits LSB first, stop(1).
REQ-018 CRC is CRC-16/CCITT: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR, over payload bytes only.
REQ-019 TX FSM states: IDLE, START, DATA, STOP (plus PARITY per REQ-035); one state per bit, each held CLKS_PER_BIT cycles.
REQ-020 tx_ready is high only in IDLE while payload index < DATA_BYTES; byte accepted when tx_valid && tx_ready; START drives tx_out low the next cycle.
REQ-021 Between payload bytes, if tx_valid is low, tx_out stays high and the frame stays open (no TX timeout).
REQ-022 After the last payload byte's STOP, the two CRC bytes are sent back-to-back without handshake; tx_ready is low throughout.
REQ-023 tx_busy is high from the first byte acceptance until the end of the second CRC byte's STOP; TX CRC and index then reinitialise.
REQ-024 rx_in passes a 2-flop synchroniser; a falling edge in RX IDLE starts a byte.
REQ-025 Start bit is rechecked at CLKS_PER_BIT/2; if high, return to IDLE silently (glitch reject).
REQ-026 Data bits are sampled at bit centres; stop bit is sampled at its centre.
REQ-027 Stop bit low: rx_frame_err pulses, RX byte index and CRC reinitialise, nothing else pulses.
REQ-028 Valid payload byte: rx_data updates and rx_valid pulses one cycle after the stop sample; RX CRC updates.
REQ-029 After the second CRC byte: rx_frame_done pulses one cycle after the stop sample, with rx_crc_ok = (received CRC == computed CRC); RX index and CRC reinitialise.
REQ-030 RX idle time of IDLE_TIMEOUT_BITS*CLKS_PER_BIT cycles with byte index nonzero: rx_frame_err pulses, frame discarded.
REQ-031 TX and RX are independent and may run simultaneously.

Reset
REQ-032 Reset asserted mid-frame aborts both directions immediately.
REQ-033 Reset values: tx_out=1, tx_ready=0, tx_busy=0, rx_data=0x00, rx_valid=0, rx_frame_done=0, rx_crc_ok=0, rx_frame_err=0; synchroniser flops =1; CRC registers =0xFFFF.
REQ-034 tx_ready rises the first cycle after reset deassertion.

Configuration
REQ-035 With UART_CRC_LINK_PARITY_EN defined, each byte carries an even-parity bit after bit 7 (TX PARITY state); an RX parity mismatch is handled as REQ-027.
REQ-036 Without UART_CRC_LINK_PARITY_EN, no parity bit is sent or expected, and no parity logic exists.

Structure
REQ-037 Package uart_crc_link_pkg holds CRC16_POLY=0x1021, CRC16_INIT=0xFFFF, the TX/RX state enum types and a byte-wide CRC update function.
REQ-038 The byte-wide CRC update is sub-module crc16_ccitt_byte (combinational: crc_in[15:0], byte[7:0] -> crc_out[15:0]), instantiated once in TX and once in RX.

Verification
REQ-039 Loopback tx_out->rx_in, DATA_BYTES=9, send "123456789" -> TX CRC bytes 0x29,0xB1; nine rx_valid pulses, then rx_frame_done=1, rx_crc_ok=1.
REQ-040 DATA_BYTES=1, send 0x00 -> line bytes 0x00,0xE1,0xF0; rx_crc_ok=1.
REQ-041 Loopback with one bit of the CRC low byte inverted on the line -> rx_frame_done=1, rx_crc_ok=0.
REQ-042 Stop bit forced low on payload byte 2 -> rx_frame_err pulse, no rx_frame_done; next clean frame -> rx_crc_ok=1.
REQ-043 Low glitch of CLKS_PER_BIT/4 cycles on idle rx_in -> no pulse on any RX output; stall for 2 payload bytes, then line idle for IDLE_TIMEOUT_BITS bit-times -> rx_frame_err pulse.
REQ-044 Reset asserted during TX bit 3 -> tx_out=1 and tx_busy=0 immediately; next frame's CRC is computed from init 0xFFFF.

Source files
------------

// File: rtl/uart_crc_link_pkg.sv
// Shared constants, FSM state types and the byte-wide CRC-16/CCITT update
// used by both link directions.
package uart_crc_link_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // MSB-first, unreflected: the byte enters the top of the register.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational one-byte step of CRC-16/CCITT (poly 0x1021).
module crc16_ccitt_byte
  import uart_crc_link_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  assign crc_out = crc16_update(crc_in, byte_in);

endmodule

// File: rtl/uart_crc_link.sv
// UART link sending/receiving fixed-length frames trailed by a CRC-16/CCITT.
// Optional even parity per byte when UART_CRC_LINK_PARITY_EN is defined.
module uart_crc_link
  import uart_crc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 16,
  parameter int DATA_BYTES        = 4,
  parameter int IDLE_TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_done,
  output logic       rx_crc_ok,
  output logic       rx_frame_err
);

  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [6:0]  N_PAY        = 7'(DATA_BYTES);
  localparam logic [31:0] TIMEOUT_LAST = 32'(IDLE_TIMEOUT_BITS * CLKS_PER_BIT - 1);

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shreg;
  logic [6:0]  tx_idx;
  logic [1:0]  tx_crc_phase;
  logic [15:0] tx_crc, tx_crc_next;
`ifdef UART_CRC_LINK_PARITY_EN
  logic        tx_par;
`endif

  crc16_ccitt_byte u_tx_crc (.crc_in(tx_crc), .byte_in(tx_data), .crc_out(tx_crc_next));

  // tx_crc_phase: 0 = payload, 1 = CRC high byte on line, 2 = CRC low byte on line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shreg     <= '0;
      tx_idx       <= '0;
      tx_crc_phase <= '0;
      tx_crc       <= CRC16_INIT;
      tx_ready     <= 1'b0;
      tx_out       <= 1'b1;
      tx_busy      <= 1'b0;
`ifdef UART_CRC_LINK_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_out <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_shreg <= tx_data;
            tx_crc   <= tx_crc_next;
            tx_idx   <= tx_idx + 7'd1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            tx_out   <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
`ifdef UART_CRC_LINK_PARITY_EN
            tx_par   <= ^tx_data;
`endif
          end else begin
            tx_ready <= (tx_idx < N_PAY);
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_out   <= tx_shreg[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
`ifdef UART_CRC_LINK_PARITY_EN
              tx_out   <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx_out   <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shreg <= tx_shreg >> 1;
              tx_out   <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
`ifdef UART_CRC_LINK_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_out   <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            // CRC bytes follow the last payload byte with no handshake.
            if (tx_crc_phase == 2'd0 && tx_idx == N_PAY) begin
              tx_shreg     <= tx_crc[15:8];
              tx_crc_phase <= 2'd1;
              tx_out       <= 1'b0;
              tx_state     <= TX_START;
`ifdef UART_CRC_LINK_PARITY_EN
              tx_par       <= ^tx_crc[15:8];
`endif
            end else if (tx_crc_phase == 2'd1) begin
              tx_shreg     <= tx_crc[7:0];
              tx_crc_phase <= 2'd2;
              tx_out       <= 1'b0;
              tx_state     <= TX_START;
`ifdef UART_CRC_LINK_PARITY_EN
              tx_par       <= ^tx_crc[7:0];
`endif
            end else if (tx_crc_phase == 2'd2) begin
              tx_crc       <= CRC16_INIT;
              tx_idx       <= '0;
              tx_crc_phase <= 2'd0;
              tx_busy      <= 1'b0;
              tx_ready     <= 1'b1;
              tx_state     <= TX_IDLE;
            end else begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shreg;
  logic [7:0]  rx_crc_hi;
  logic [6:0]  rx_idx;
  logic [15:0] rx_crc, rx_crc_next;
  logic [31:0] rx_idle_cnt;
`ifdef UART_CRC_LINK_PARITY_EN
  logic        rx_par_err;
`endif

  crc16_ccitt_byte u_rx_crc (.crc_in(rx_crc), .byte_in(rx_shreg), .crc_out(rx_crc_next));

  // rx_s3 is the previous synchronised level, used only for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shreg      <= '0;
      rx_crc_hi     <= '0;
      rx_idx        <= '0;
      rx_crc        <= CRC16_INIT;
      rx_idle_cnt   <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_done <= 1'b0;
      rx_crc_ok     <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_CRC_LINK_PARITY_EN
      rx_par_err    <= 1'b0;
`endif
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_done <= 1'b0;
      rx_frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_CRC_LINK_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
`ifdef UART_CRC_LINK_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt     <= '0;
            rx_par_err <= rx_s2 ^ (^rx_shreg);
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
`ifdef UART_CRC_LINK_PARITY_EN
            if (!rx_s2 || rx_par_err) begin
`else
            if (!rx_s2) begin
`endif
              rx_frame_err <= 1'b1;
              rx_idx       <= '0;
              rx_crc       <= CRC16_INIT;
            end else if (rx_idx < N_PAY) begin
              rx_data  <= rx_shreg;
              rx_valid <= 1'b1;
              rx_crc   <= rx_crc_next;
              rx_idx   <= rx_idx + 7'd1;
            end else if (rx_idx == N_PAY) begin
              rx_crc_hi <= rx_shreg;
              rx_idx    <= rx_idx + 7'd1;
            end else begin
              rx_frame_done <= 1'b1;
              rx_crc_ok     <= ({rx_crc_hi, rx_shreg} == rx_crc);
              rx_idx        <= '0;
              rx_crc        <= CRC16_INIT;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase

      // A partial frame left idle too long is thrown away.
      if (rx_state == RX_IDLE && rx_idx != 7'd0) begin
        if (rx_idle_cnt == TIMEOUT_LAST) begin
          rx_idle_cnt  <= '0;
          rx_frame_err <= 1'b1;
          rx_idx       <= '0;
          rx_crc       <= CRC16_INIT;
        end else begin
          rx_idle_cnt <= rx_idle_cnt + 32'd1;
        end
      end else begin
        rx_idle_cnt <= '0;
      end
    end
  end

endmodule
